// File: rtl/video_write_bridge.sv
// Video store bridge: range-checks and aligns core video stores, queues them
// in a first-word-fall-through FIFO, and drains them to VRAM under valid/ready.
module video_write_bridge #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] VRAM_BASE = 32'h0000_8000,
  parameter int unsigned VRAM_AW   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              video_addr,
  input  logic [31:0]              video_data,
  input  logic                     video_we,
  output logic [VRAM_AW-1:0]       vram_addr,
  output logic [31:0]              vram_wdata,
  output logic                     vram_we,
  input  logic                     vram_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              reject_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = VRAM_AW + 32;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0]      r_mem [DEPTH];
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [LW-1:0]      r_level;
  logic               r_ovf;
  logic [15:0]        r_drop;
  logic [15:0]        r_rej;

  logic [31:0]        w_off;
  logic [VRAM_AW-1:0] w_idx;
  logic               w_addr_ok;
  logic               w_legal;
  logic               w_reject;
  logic               w_pop;
  logic               w_full;
  logic               w_accept;
  logic               w_drop;

  // Offset must fit in VRAM_AW word-index bits: everything above them must be zero.
  assign w_off     = video_addr - VRAM_BASE;
  assign w_idx     = w_off[VRAM_AW+1:2];
  assign w_addr_ok = (video_addr >= VRAM_BASE) && (video_addr[1:0] == 2'b00) &&
                     ((w_off >> (VRAM_AW + 2)) == 32'd0);
  assign w_legal   = video_we && w_addr_ok;
  assign w_reject  = video_we && !w_addr_ok;

  assign w_full    = (r_level == FULL_LVL);
  assign w_pop     = (r_level != '0) && vram_ready;
  assign w_accept  = w_legal && (!w_full || w_pop);
  assign w_drop    = w_legal && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
      r_rej   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr] <= {w_idx, video_data};
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);

      if (w_accept && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_accept && w_pop) r_level <= r_level - LW'(1);

      // A drop coinciding with a clear restarts the count at one.
      if (w_drop) begin
        r_ovf  <= 1'b1;
        r_drop <= overflow_clr ? 16'd1 : sat_inc16(r_drop);
      end else if (overflow_clr) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end

      if (w_reject) r_rej <= sat_inc16(r_rej);
    end
  end

  assign vram_addr  = r_mem[r_rd][EW-1:32];
  assign vram_wdata = r_mem[r_rd][31:0];
  assign vram_we    = (r_level != '0);
  assign fifo_level = r_level;
  assign overflow   = r_ovf;
  assign drop_cnt   = r_drop;
  assign reject_cnt = r_rej;

endmodule
